bit_unstuff: RTL and testbench

Receive-side counterpart of the transmit bit stuffer. It consumes a serial stream in which a 0 follows every run of RUN_LEN consecutive 1s, and removes that inserted 0. Output is a serial stream with a qualifying valid. A violation, a 1 where a stuffed 0 is required, is flagged and latched until the next packet clear. It sits between the line sampler and the receive deserializer.

---
 rtl/rx_pkg.sv | 9 +
 rtl/bit_unstuff_counter.sv | 28 ++
 rtl/bit_unstuff.sv | 112 +++++++++++
 tb/tb_bit_unstuff.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared receive-path types and defaults
package rx_pkg;

    typedef enum logic [1:0] {COUNT, STRIP, ERR} unstuff_state_t;

    // Same default as the transmit stuffer so both ends agree on the run length.
    localparam int DEF_RUN_LEN = 6;

endpackage

// File: rtl/bit_unstuff_counter.sv
// rtl/bit_unstuff_counter.sv - run-length counter primitive with clear and step
module bit_unstuff_counter #(
    parameter int W  = 4,
    parameter bit UP = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] base;

    // clr and inc together restart the count at one step from zero.
    assign base = clr ? '0 : count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= UP ? base + W'(1) : base - W'(1);
        end else if (clr) begin
            count <= '0;
        end
    end

endmodule

// File: rtl/bit_unstuff.sv
// rtl/bit_unstuff.sv - removes stuffed zeros after runs of RUN_LEN ones
module bit_unstuff import rx_pkg::*; #(
    parameter int RUN_LEN = DEF_RUN_LEN,
    parameter int CNT_W   = 4,
    parameter int STAT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic              inb,
    output logic              outb,
    output logic              out_valid,
    output logic              stuff_err,
    output logic              err,
    output logic [STAT_W-1:0] strip_cnt
);

    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_LEN - 1);

    unstuff_state_t   state_q, state_d;
    logic [CNT_W-1:0] run;
    logic             run_clr, run_inc;
    logic             outb_d, out_valid_d, stuff_err_d, err_d, strip_inc;

    bit_unstuff_counter #(
        .W  (CNT_W),
        .UP (1'b1)
    ) u_run (
        .clk   (clk),
        .rst   (rst),
        .clr   (run_clr),
        .inc   (run_inc),
        .count (run)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= COUNT;
            outb      <= 1'b0;
            out_valid <= 1'b0;
            stuff_err <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            outb      <= outb_d;
            out_valid <= out_valid_d;
            stuff_err <= stuff_err_d;
            err       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        run_clr     = 1'b0;
        run_inc     = 1'b0;
        outb_d      = outb;
        out_valid_d = 1'b0;
        stuff_err_d = 1'b0;
        err_d       = err;
        strip_inc   = 1'b0;
        if (clear) begin
            // A bit arriving with clear opens the new packet from COUNT, run=0.
            state_d = COUNT;
            run_clr = 1'b1;
            err_d   = 1'b0;
            if (in_valid) begin
                outb_d      = inb;
                out_valid_d = 1'b1;
                run_inc     = inb;
            end
        end else if (in_valid) begin
            unique case (state_q)
                COUNT: begin
                    outb_d      = inb;
                    out_valid_d = 1'b1;
                    if (!inb) begin
                        run_clr = 1'b1;
                    end else if (run < RUN_LAST) begin
                        run_inc = 1'b1;
                    end else begin
                        run_clr = 1'b1;
                        state_d = STRIP;
                    end
                end
                STRIP: begin
                    if (!inb) begin
                        strip_inc = 1'b1;
                        state_d   = COUNT;
                    end else begin
                        stuff_err_d = 1'b1;
                        err_d       = 1'b1;
                        state_d     = ERR;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strip_cnt <= '0;
        end else if (clear) begin
            strip_cnt <= '0;
        end else if (strip_inc && (strip_cnt != '1)) begin
            strip_cnt <= strip_cnt + STAT_W'(1);
        end
    end

endmodule

// File: tb/tb_bit_unstuff.sv
// tb/tb_bit_unstuff.sv - vector table and scoreboard bench for bit_unstuff
module tb_bit_unstuff;

    logic       clk = 1'b0;
    logic       rst, clear, in_valid, inb;
    logic       outb, out_valid, stuff_err, err;
    logic [7:0] strip_cnt;
    logic       outb2, out_valid2, stuff_err2, err2;
    logic [1:0] strip_cnt2;

    always #5 clk = ~clk;

    bit_unstuff dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .inb(inb),
        .outb(outb), .out_valid(out_valid), .stuff_err(stuff_err), .err(err),
        .strip_cnt(strip_cnt)
    );

    bit_unstuff #(.STAT_W(2)) dut2 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .inb(inb),
        .outb(outb2), .out_valid(out_valid2), .stuff_err(stuff_err2), .err(err2),
        .strip_cnt(strip_cnt2)
    );

    typedef struct {
        logic clear, in_valid, inb;
        logic eo, eov, ese, ee;
        int   es, es2;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic c, input logic v, input logic b, input logic eo,
                       input logic eov, input logic ese, input logic ee, input int es);
        vec_t t;
        t.clear = c; t.in_valid = v; t.inb = b;
        t.eo = eo; t.eov = eov; t.ese = ese; t.ee = ee;
        t.es = es; t.es2 = (es > 3) ? 3 : es;
        vecs.push_back(t);
    endtask

    task automatic fwd(input int n, input int es);
        for (int i = 0; i < n; i++) add(0, 1, 1, 1, 1, 0, 0, es);
    endtask

    task automatic drive(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        clear = v.clear; in_valid = v.in_valid; inb = v.inb;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk($sformatf("v%0d out_valid", idx), int'(out_valid), int'(e.eov));
        if (e.eov) chk($sformatf("v%0d outb", idx), int'(outb), int'(e.eo));
        chk($sformatf("v%0d stuff_err", idx), int'(stuff_err), int'(e.ese));
        chk($sformatf("v%0d err", idx), int'(err), int'(e.ee));
        chk($sformatf("v%0d strip_cnt", idx), int'(strip_cnt), e.es);
        chk($sformatf("v%0d out_valid2", idx), int'(out_valid2), int'(e.eov));
        chk($sformatf("v%0d strip_cnt2", idx), int'(strip_cnt2), e.es2);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; inb = 1'b0;
        #3;
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset outb", int'(outb), 0);
        chk("reset stuff_err", int'(stuff_err), 0);
        chk("reset err", int'(err), 0);
        chk("reset strip_cnt", int'(strip_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // short runs forwarded as-is
        add(0, 1, 1, 1, 1, 0, 0, 0);
        add(0, 1, 1, 1, 1, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0, 0);
        add(0, 1, 1, 1, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0);
        // six ones, stuffed zero dropped, then a payload one
        fwd(6, 0);
        add(0, 1, 0, 0, 0, 0, 0, 1);
        add(0, 1, 1, 1, 1, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0);
        // seventh one is a violation; ERR swallows everything until clear
        fwd(6, 0);
        add(0, 1, 1, 0, 0, 1, 1, 0);
        add(0, 1, 1, 0, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 1, 0, 0, 1, 0, 0, 0);
        // clear in STRIP with a one: forwarded, run restarts at 1
        fwd(6, 0);
        add(1, 1, 1, 1, 1, 0, 0, 0);
        fwd(5, 0);
        add(0, 1, 0, 0, 0, 0, 0, 1);
        add(0, 1, 1, 1, 1, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0);
        // idle gaps hold the run and hold STRIP
        fwd(3, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        fwd(3, 0);
        add(0, 1, 0, 0, 0, 0, 0, 1);
        fwd(6, 1);
        add(0, 0, 1, 0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 0, 2);
        add(1, 0, 0, 0, 0, 0, 0, 0);
        // zero after five ones is payload
        fwd(5, 0);
        add(0, 1, 0, 0, 1, 0, 0, 0);
        // four stuffed sequences: STAT_W=2 copy saturates at 3
        for (int k = 0; k < 4; k++) begin
            fwd(6, k);
            add(0, 1, 0, 0, 0, 0, 0, k + 1);
        end
        add(1, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) drive(vecs[i], i);

        // asynchronous reset mid-run abandons the partial run
        vecs.delete();
        fwd(3, 0);
        for (int i = 0; i < vecs.size(); i++) drive(vecs[i], 1000 + i);
        #1 rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("async rst out_valid", int'(out_valid), 0);
        chk("async rst outb", int'(outb), 0);
        chk("async rst strip_cnt2", int'(strip_cnt2), 0);
        #1 rst = 1'b0;
        vecs.delete();
        fwd(5, 0);
        add(0, 1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < vecs.size(); i++) drive(vecs[i], 2000 + i);

        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard leftover: got %0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
